// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between the chip pads and the register-bank slave.
// The master modport is the pad side (driver of sclk/copi/ncs); the slave modport is the register bank.
interface spi_reg_bank_if;
  logic sclk;
  logic copi;
  logic ncs;
  logic cipo;
  logic cipo_oe;

  modport master (output sclk, output copi, output ncs, input cipo, input cipo_oe);
  modport slave  (input sclk, input copi, input ncs, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave owning NUM_REGS read/write registers, exposed as a flat vector.
// A write commits on the 3rd clk edge after ncs rises; cipo follows the sclk pins by 3 clk edges.
module spi_reg_bank #(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  spi_reg_bank_if.slave                spi,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  output logic                         wr_stb,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [7:0]                   err_cnt
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(FRAME_W + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  CNT_PRELD  = CNT_W'(ADDR_W);
  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  logic [2:0]                 sclk_q, sclk_d;
  logic [2:0]                 ncs_q, ncs_d;
  logic [1:0]                 copi_q, copi_d;
  logic [FRAME_W-1:0]         rx_q, rx_d;
  logic [DATA_W-1:0]          tx_q, tx_d;
  logic [CNT_W-1:0]           bit_cnt_q, bit_cnt_d;
  logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
  logic                       wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;
  logic [7:0]                 err_cnt_q, err_cnt_d;

  logic               sclk_rise, sclk_fall, ncs_rise, ncs_fall, active;
  logic [FRAME_W-1:0] rx_shift;
  logic               ld_rw;
  logic [ADDR_W-1:0]  ld_addr, frm_addr;
  logic               frm_rw, frm_ok;
  logic [DATA_W-1:0]  frm_data, rd_sel;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign ncs_rise  = ncs_q[1] & ~ncs_q[2];
  assign ncs_fall  = ~ncs_q[1] & ncs_q[2];
  assign active    = ~ncs_q[1];

  assign rx_shift = {rx_q[FRAME_W-2:0], copi_q[1]};
  assign ld_rw    = rx_shift[ADDR_W];
  assign ld_addr  = rx_shift[ADDR_W-1:0];
  assign frm_rw   = rx_q[FRAME_W-1];
  assign frm_addr = rx_q[DATA_W +: ADDR_W];
  assign frm_data = rx_q[DATA_W-1:0];
  assign frm_ok   = (bit_cnt_q == CNT_FULL) && ({1'b0, frm_addr} < NUM_REGS_W);

  always_comb begin
    sclk_d    = {sclk_q[1:0], spi.sclk};
    ncs_d     = {ncs_q[1:0], spi.ncs};
    copi_d    = {copi_q[0], spi.copi};
    rx_d      = rx_q;
    tx_d      = tx_q;
    bit_cnt_d = bit_cnt_q;
    regs_d    = regs_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    err_cnt_d = err_cnt_q;
    rd_sel    = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if ({1'b0, ld_addr} == (ADDR_W + 1)'(k)) rd_sel = regs_q[k*DATA_W +: DATA_W];
    end

    if (ncs_fall) begin
      rx_d      = '0;
      tx_d      = '0;
      bit_cnt_d = '0;
    end else if (ncs_rise) begin
      rx_d      = '0;
      tx_d      = '0;
      bit_cnt_d = '0;
      if (frm_ok) begin
        if (frm_rw) begin
          for (int k = 0; k < NUM_REGS; k++) begin
            if ({1'b0, frm_addr} == (ADDR_W + 1)'(k)) regs_d[k*DATA_W +: DATA_W] = frm_data;
          end
          wr_stb_d  = 1'b1;
          wr_addr_d = frm_addr;
        end
      end else if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end else if (active) begin
      if (sclk_rise) begin
        rx_d = rx_shift;
        if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + CNT_W'(1);
        // Address just completed on a read: out-of-range addresses leave rd_sel at zero.
        if (bit_cnt_q == CNT_PRELD && !ld_rw) tx_d = rd_sel;
      end else if (sclk_fall) begin
        tx_d = {tx_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q    <= '0;
      ncs_q     <= '1;
      copi_q    <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      bit_cnt_q <= '0;
      regs_q    <= '0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      err_cnt_q <= '0;
    end else begin
      sclk_q    <= sclk_d;
      ncs_q     <= ncs_d;
      copi_q    <= copi_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      bit_cnt_q <= bit_cnt_d;
      regs_q    <= regs_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign spi.cipo    = active & tx_q[DATA_W-1];
  assign spi.cipo_oe = active;
  assign regs_o      = regs_q;
  assign wr_stb      = wr_stb_q;
  assign wr_addr     = wr_addr_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: table of SPI frames with expected register/error state,
// scoreboards for write strobes and read-back bytes, plus reset-abort and saturation sequences.
module tb_spi_reg_bank;
  localparam int NR = 5;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int PH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_reg_bank_if spi ();
  logic [NR*DW-1:0] regs_o;
  logic             wr_stb;
  logic [AW-1:0]    wr_addr;
  logic [7:0]       err_cnt;

  spi_reg_bank #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .spi     (spi),
    .regs_o  (regs_o),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .err_cnt (err_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int stb_total = 0;

  logic [AW+DW-1:0] wr_q[$];
  logic [DW-1:0]    rd_q[$];
  logic [AW+DW-1:0] wr_e;

  typedef struct {
    logic [63:0] frm;
    int          nbits;
    logic        is_wr;
    int          chk_reg;
    logic [7:0]  exp_reg;
    logic [7:0]  exp_err;
    logic        is_rd;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Write-strobe scoreboard: each strobe must match the oldest expected commit.
  always @(negedge clk) begin
    if (wr_stb) begin
      stb_total++;
      if (wr_q.size() == 0) begin
        chk("unexpected_wr_stb", 64'd1, 64'd0);
      end else begin
        wr_e = wr_q.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(wr_e[DW +: AW]));
        chk("wr_data", 64'(regs_o[int'(wr_e[DW +: AW])*DW +: DW]), 64'(wr_e[DW-1:0]));
      end
    end
  end

  task automatic shift_bits(input logic [63:0] frm, input int n, output logic [7:0] rd, output int oe_low);
    rd = '0;
    oe_low = 0;
    for (int i = 0; i < n; i++) begin
      spi.copi = frm[n-1-i];
      tick(PH);
      spi.sclk = 1'b1;
      tick(PH);
      if (spi.cipo_oe !== 1'b1) oe_low++;
      if (i >= AW && i < AW + DW) rd[AW+DW-1-i] = spi.cipo;
      spi.sclk = 1'b0;
    end
    spi.copi = 1'b0;
  endtask

  task automatic frame(input logic [63:0] frm, input int n, output logic [7:0] rd, output int oe_low);
    spi.ncs = 1'b0;
    tick(PH);
    shift_bits(frm, n, rd, oe_low);
    tick(PH);
    spi.ncs = 1'b1;
    tick(8);
  endtask

  logic [7:0]       rd, exp_b;
  int               oe_low, s0;
  logic [NR*DW-1:0] regs_before;

  initial begin
    spi.sclk = 1'b0;
    spi.copi = 1'b0;
    spi.ncs  = 1'b1;

    vecs[0]  = '{64'h84AB,          16, 1'b1, 4, 8'hAB, 8'd0, 1'b0, 8'h00};
    vecs[1]  = '{64'h0400,          16, 1'b0, 4, 8'hAB, 8'd0, 1'b1, 8'hAB};
    vecs[2]  = '{64'h8555,          16, 1'b0, 4, 8'hAB, 8'd1, 1'b0, 8'h00};
    vecs[3]  = '{64'h0500,          16, 1'b0, 0, 8'h00, 8'd2, 1'b1, 8'h00};
    vecs[4]  = '{64'h407F,          15, 1'b0, 0, 8'h00, 8'd3, 1'b0, 8'h00};
    vecs[5]  = '{64'h101FF,         17, 1'b0, 0, 8'h00, 8'd4, 1'b0, 8'h00};
    vecs[6]  = '{64'hFFFF_FFFF_8011, 48, 1'b0, 0, 8'h00, 8'd5, 1'b0, 8'h00};
    vecs[7]  = '{64'h8077,          16, 1'b1, 0, 8'h77, 8'd5, 1'b0, 8'h00};
    vecs[8]  = '{64'h0000,          16, 1'b0, 0, 8'h77, 8'd5, 1'b1, 8'h77};
    vecs[9]  = '{64'h82C3,          16, 1'b1, 2, 8'hC3, 8'd5, 1'b0, 8'h00};
    vecs[10] = '{64'h0200,          16, 1'b0, 2, 8'hC3, 8'd5, 1'b1, 8'hC3};

    tick(3);
    rst_n = 1'b1;
    tick(3);
    chk("rst_regs_o",  64'(regs_o), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_wr_stb",  64'(wr_stb), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_cipo",    64'(spi.cipo), 64'd0);
    chk("rst_cipo_oe", 64'(spi.cipo_oe), 64'd0);

    for (int v = 0; v < 11; v++) begin
      s0 = stb_total;
      regs_before = regs_o;
      if (vecs[v].is_wr) wr_q.push_back(vecs[v].frm[AW+DW-1:0]);
      if (vecs[v].is_rd) rd_q.push_back(vecs[v].exp_rd);
      frame(vecs[v].frm, vecs[v].nbits, rd, oe_low);
      chk($sformatf("v%0d_stb_count", v), 64'(stb_total - s0), vecs[v].is_wr ? 64'd1 : 64'd0);
      chk($sformatf("v%0d_reg%0d", v, vecs[v].chk_reg), 64'(regs_o[vecs[v].chk_reg*DW +: DW]), 64'(vecs[v].exp_reg));
      chk($sformatf("v%0d_err_cnt", v), 64'(err_cnt), 64'(vecs[v].exp_err));
      chk($sformatf("v%0d_oe_in_frame", v), 64'(oe_low), 64'd0);
      chk($sformatf("v%0d_oe_idle", v), 64'(spi.cipo_oe), 64'd0);
      chk($sformatf("v%0d_cipo_idle", v), 64'(spi.cipo), 64'd0);
      if (vecs[v].is_rd) begin
        exp_b = rd_q.pop_front();
        chk($sformatf("v%0d_read_data", v), 64'(rd), 64'(exp_b));
        chk($sformatf("v%0d_read_regs_same", v), 64'(regs_o), 64'(regs_before));
      end
    end

    // Reset in the middle of a write frame.
    spi.ncs = 1'b0;
    tick(PH);
    shift_bits(64'h204, 10, rd, oe_low);
    rst_n = 1'b0;
    tick(2);
    chk("midrst_regs_o",  64'(regs_o), 64'd0);
    chk("midrst_err_cnt", 64'(err_cnt), 64'd0);
    chk("midrst_wr_stb",  64'(wr_stb), 64'd0);
    chk("midrst_wr_addr", 64'(wr_addr), 64'd0);
    chk("midrst_cipo",    64'(spi.cipo), 64'd0);
    chk("midrst_cipo_oe", 64'(spi.cipo_oe), 64'd0);
    spi.ncs = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    s0 = stb_total;
    wr_q.push_back(15'h0133);
    frame(64'h8133, 16, rd, oe_low);
    chk("postrst_reg1", 64'(regs_o[1*DW +: DW]), 64'h33);
    chk("postrst_stb_count", 64'(stb_total - s0), 64'd1);
    chk("postrst_err_cnt", 64'(err_cnt), 64'd0);

    // Error counter saturation.
    for (int f = 0; f < 260; f++) begin
      frame(64'h407F, 15, rd, oe_low);
      if (f == 253) chk("sat_err_254", 64'(err_cnt), 64'd254);
      if (f == 254) chk("sat_err_255", 64'(err_cnt), 64'd255);
    end
    chk("sat_err_hold", 64'(err_cnt), 64'd255);
    chk("sat_reg0", 64'(regs_o[0 +: DW]), 64'h00);
    s0 = stb_total;
    wr_q.push_back(15'h0399);
    frame(64'h8399, 16, rd, oe_low);
    chk("sat_write_reg3", 64'(regs_o[3*DW +: DW]), 64'h99);
    chk("sat_write_stb", 64'(stb_total - s0), 64'd1);
    chk("sat_write_err", 64'(err_cnt), 64'd255);

    chk("wr_queue_drained", 64'(wr_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
